// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX byte interface among P_NUM_REQ sources,
// one byte per grant, with an inter-byte gap and a timeout that drops a stalled byte.
module uart_tx_arbiter #(
    parameter int P_NUM_REQ    = 4,
    parameter int P_DATA_WIDTH = 8,
    parameter int P_GAP_CYCLES = 1,
    parameter int P_TIMEOUT    = 65535
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [P_NUM_REQ-1:0]              i_req_valid,
    input  logic [P_NUM_REQ*P_DATA_WIDTH-1:0] i_req_data,
    output logic [P_NUM_REQ-1:0]              o_req_ready,
    output logic [P_NUM_REQ-1:0]              o_req_err,
    output logic [P_NUM_REQ-1:0]              o_grant,
    output logic                              o_busy,
    output logic                              o_user_tx_valid,
    output logic [P_DATA_WIDTH-1:0]           o_user_tx_data,
    input  logic                              i_user_tx_ready
);
    localparam int IW = $clog2(P_NUM_REQ);
    localparam int TW = P_TIMEOUT > 0 ? $clog2(P_TIMEOUT + 1) : 1;
    localparam int GW = P_GAP_CYCLES > 1 ? $clog2(P_GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(P_TIMEOUT > 0 ? P_TIMEOUT - 1 : 0);
    localparam logic [GW-1:0] GAP_LAST = GW'(P_GAP_CYCLES > 0 ? P_GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t                  state;
    logic [IW-1:0]           ptr, cur, pick, cand;
    logic [TW-1:0]           tcnt;
    logic [GW-1:0]           gcnt;
    logic [P_NUM_REQ-1:0]    eligible;
    logic                    hit, accept, timeout;
    logic [P_DATA_WIDTH-1:0] bytes [P_NUM_REQ];

    always_comb begin
        for (int k = 0; k < P_NUM_REQ; k++) bytes[k] = i_req_data[k*P_DATA_WIDTH +: P_DATA_WIDTH];
    end

    // A requester is skipped while its own completion pulse is showing, so a held valid is not re-sent.
    assign eligible = i_req_valid & ~o_req_ready & ~o_req_err;
    assign accept   = o_user_tx_valid & i_user_tx_ready;
    assign timeout  = (P_TIMEOUT != 0) && (tcnt == TO_LAST);

    // Scan farthest-first so the candidate nearest after ptr overwrites the others.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        cand = '0;
        for (int i = P_NUM_REQ; i >= 1; i--) begin
            cand = IW'((int'(ptr) + i) % P_NUM_REQ);
            if (eligible[cand]) begin
                hit  = 1'b1;
                pick = cand;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state           <= IDLE;
            ptr             <= IW'(P_NUM_REQ - 1);
            cur             <= '0;
            tcnt            <= '0;
            gcnt            <= '0;
            o_req_ready     <= '0;
            o_req_err       <= '0;
            o_grant         <= '0;
            o_busy          <= 1'b0;
            o_user_tx_valid <= 1'b0;
            o_user_tx_data  <= '0;
        end else begin
            o_req_ready <= '0;
            o_req_err   <= '0;
            case (state)
                IDLE: if (hit) begin
                    state           <= SEND;
                    cur             <= pick;
                    tcnt            <= '0;
                    o_grant         <= P_NUM_REQ'(1) << pick;
                    o_user_tx_valid <= 1'b1;
                    o_user_tx_data  <= bytes[pick];
                    o_busy          <= 1'b1;
                end
                SEND: if (accept || timeout) begin
                    state            <= P_GAP_CYCLES > 0 ? GAP : IDLE;
                    ptr              <= cur;
                    gcnt             <= '0;
                    o_req_ready[cur] <= accept;
                    o_req_err[cur]   <= ~accept;
                    o_grant          <= '0;
                    o_user_tx_valid  <= 1'b0;
                    o_busy           <= P_GAP_CYCLES > 0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
                GAP: if (gcnt == GAP_LAST) begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end else begin
                    gcnt <= gcnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random checks of two arbiter configurations
// against a transaction-level reference model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 16;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  va = '0, vb = '0;
    logic [31:0] da = '0, db = '0;
    logic        tra = 1'b0, trb = 1'b0;
    logic [3:0]  rdy_a, err_a, gnt_a, rdy_b, err_b, gnt_b;
    logic        busy_a, busy_b, txv_a, txv_b;
    logic [7:0]  txd_a, txd_b;
    int          n_chk = 0, n_fail = 0;
    int          n, pulses;
    logic [7:0]  q [$];

    typedef struct packed {
        logic       act;
        int         owner;
        int         gap_left;
        int         last;
        int         sent;
        logic [7:0] data;
        logic [3:0] rdy;
        logic [3:0] err;
    } mdl_t;

    mdl_t ma, mb;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.P_NUM_REQ(N), .P_DATA_WIDTH(8), .P_GAP_CYCLES(1), .P_TIMEOUT(TO)) u_dut_a (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .i_req_valid(va), .i_req_data(da),
        .o_req_ready(rdy_a), .o_req_err(err_a), .o_grant(gnt_a), .o_busy(busy_a),
        .o_user_tx_valid(txv_a), .o_user_tx_data(txd_a), .i_user_tx_ready(tra));

    uart_tx_arbiter #(.P_NUM_REQ(N), .P_DATA_WIDTH(8), .P_GAP_CYCLES(0), .P_TIMEOUT(0)) u_dut_b (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .i_req_valid(vb), .i_req_data(db),
        .o_req_ready(rdy_b), .o_req_err(err_b), .o_grant(gnt_b), .o_busy(busy_b),
        .o_user_tx_valid(txv_b), .o_user_tx_data(txd_b), .i_user_tx_ready(trb));

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.act = 1'b0; r.owner = 0; r.gap_left = 0; r.last = N - 1; r.sent = 0;
        r.data = '0; r.rdy = '0; r.err = '0;
        return r;
    endfunction

    // One byte per grant; the source holding the next turn after the last owner wins.
    function automatic mdl_t mdl_next(mdl_t s, logic [3:0] v, logic [31:0] d, logic tr, int gap, int to);
        mdl_t r = s;
        r.rdy = '0;
        r.err = '0;
        if (!s.act && s.gap_left == 0) begin
            for (int off = N; off >= 1; off--) begin
                int k = (s.last + off) % N;
                if (v[k] && !s.rdy[k] && !s.err[k]) begin
                    r.act = 1'b1; r.owner = k; r.data = d[k*8 +: 8]; r.sent = 0;
                end
            end
        end else if (s.act) begin
            r.sent = s.sent + 1;
            if (tr || (to != 0 && r.sent == to)) begin
                if (tr) r.rdy[s.owner] = 1'b1;
                else    r.err[s.owner] = 1'b1;
                r.last = s.owner; r.act = 1'b0; r.gap_left = gap;
            end
        end else begin
            r.gap_left = s.gap_left - 1;
        end
        return r;
    endfunction

    task automatic compare(string id, mdl_t m, logic txv, logic [7:0] txd, logic [3:0] g,
                           logic busy, logic [3:0] r, logic [3:0] e);
        check({id, ".tx"}, 32'({txv, txd}), 32'({m.act, m.data}));
        check({id, ".grant"}, 32'({g, busy}),
              32'({m.act ? 4'(1 << m.owner) : 4'd0, m.act || m.gap_left > 0}));
        check({id, ".pulse"}, 32'({r, e}), 32'({m.rdy, m.err}));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) begin
            ma = mdl_reset();
            mb = mdl_reset();
        end else begin
            ma = mdl_next(ma, va, da, tra, 1, TO);
            mb = mdl_next(mb, vb, db, trb, 0, 0);
        end
        #1;
        compare("a", ma, txv_a, txd_a, gnt_a, busy_a, rdy_a, err_a);
        compare("b", mb, txv_b, txd_b, gnt_b, busy_b, rdy_b, err_b);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; va = '0; vb = '0; tra = 1'b0; trb = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        ma = mdl_reset();
        mb = mdl_reset();
        do_reset();
        check("rst.outputs", 32'({txv_a, txd_a, gnt_a, busy_a, rdy_a, err_a}), 32'd0);

        va = 4'b0001; da = 32'h0000_00A5; tra = 1'b1;
        tick();
        check("t1.data", 32'({txv_a, txd_a}), 32'h1A5);
        check("t1.grant", 32'(gnt_a), 32'h1);
        tick();
        check("t1.ready", 32'(rdy_a), 32'h1);
        check("t1.gap_busy", 32'(busy_a), 32'h1);
        va = '0;
        tick();
        check("t1.idle", 32'(busy_a), 32'h0);

        do_reset();
        va = 4'hF; da = 32'h1312_1110; tra = 1'b1; q.delete();
        for (int c = 0; c < 40 && q.size() < 5; c++) begin
            tick();
            if (txv_a) q.push_back(txd_a);
            check("t2.onehot", 32'($onehot0(gnt_a)), 32'h1);
        end
        check("t2.count", q.size(), 5);
        for (int i = 0; i < q.size(); i++) check("t2.order", 32'(q[i]), 32'h10 + i % 4);
        va = '0;
        repeat (3) tick();

        do_reset();
        va = 4'b1100; da = 32'h775C_0000; tra = 1'b0;
        tick();
        check("t3.grant", 32'({gnt_a, txd_a}), 32'h45C);
        n = 0;
        while (txv_a && n < 40) begin
            n++;
            tick();
        end
        check("t3.valid_cycles", n, TO);
        check("t3.err", 32'(err_a), 32'h4);
        check("t3.no_ready", 32'(rdy_a), 32'h0);
        va[2] = 1'b0;
        tick();
        tick();
        check("t3.next_grant", 32'(gnt_a), 32'h8);
        tra = 1'b1;
        tick();
        check("t3.next_ready", 32'(rdy_a), 32'h8);
        va = '0;
        repeat (2) tick();

        do_reset();
        va = 4'b0001; da = 32'h0000_003C; tra = 1'b0;
        tick();
        repeat (TO - 1) tick();
        check("t4.still_valid", 32'(txv_a), 32'h1);
        tra = 1'b1;
        tick();
        check("t4.ready", 32'(rdy_a), 32'h1);
        check("t4.no_err", 32'(err_a), 32'h0);
        va = '0;
        repeat (2) tick();

        do_reset();
        va = 4'b0010; da = 32'h0000_4400; tra = 1'b0;
        tick();
        check("t5.send", 32'({txv_a, gnt_a}), 32'h12);
        #3 rst_n = 1'b0;
        #1 check("t5.async", 32'({txv_a, gnt_a, busy_a}), 32'h0);
        ma = mdl_reset();
        mb = mdl_reset();
        va = 4'b0011; da = 32'h0000_4411; tra = 1'b1;
        #2 rst_n = 1'b1;
        tick();
        check("t5.first", 32'(gnt_a), 32'h1);
        va = '0;
        repeat (3) tick();

        do_reset();
        vb = 4'b0010; db = 32'h0000_0100; trb = 1'b1; q.delete(); pulses = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (txv_b) q.push_back(txd_b);
            if (rdy_b[1]) begin
                pulses++;
                if (pulses < 3) db[15:8] = 8'(pulses + 1);
                else vb = '0;
            end
        end
        check("t6.pulses", pulses, 3);
        check("t6.count", q.size(), 3);
        for (int i = 0; i < q.size(); i++) check("t6.byte", 32'(q[i]), i + 1);

        do_reset();
        for (int c = 0; c < 400; c++) begin
            tra = (c % 100 < 25) ? 1'b0 : 1'($urandom_range(0, 3) != 0);
            trb = (c % 90 < 20) ? 1'b0 : 1'($urandom_range(0, 2) != 0);
            for (int k = 0; k < N; k++) begin
                if (ma.rdy[k] || ma.err[k]) begin
                    va[k] = 1'($urandom_range(0, 1));
                    da[k*8 +: 8] = 8'($urandom);
                end else if (!va[k] && $urandom_range(0, 3) == 0) begin
                    va[k] = 1'b1;
                    da[k*8 +: 8] = 8'($urandom);
                end
                if (k == N - 1) continue;
                if (mb.rdy[k] || mb.err[k]) begin
                    vb[k] = 1'($urandom_range(0, 1));
                    db[k*8 +: 8] = 8'($urandom);
                end else if (!vb[k] && $urandom_range(0, 2) == 0) begin
                    vb[k] = 1'b1;
                    db[k*8 +: 8] = 8'($urandom);
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
